multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Parametrised multi-cycle control unit for the MIPS-subset datapath. It replaces the single-cycle opcode decoder with a registered Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks. Memory states take either a fixed latency or wait on a ready handshake. It also flags illegal opcodes and counts retired instructions. It sits between the instruction register (IR) opcode field and the shared-memory multi-cycle datapath.

Parameters:
OPCODE_W, 6, opcode field width.
MEM_MODE, 0, 0 = fixed latency of MEM_LAT cycles per memory access; 1 = wait for mem_ready.
MEM_LAT, 1, cycles per memory access when MEM_MODE=0; legal range 1..15.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
opcode  in  OPCODE_W  IR[31:26], sampled in DECODE.
mem_ready  in  1  memory access complete; ignored when MEM_MODE=0.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load if ALU zero.
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
MemtoReg  out  1  register write data select: 1 = MDR.
IRWrite  out  1  IR load.
PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
ALUOp  out  2  ALU operation: 00 = add, 01 = subtract, 10 = funct field.
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
RegWrite  out  1  register file write enable.
RegDst  out  1  destination register select: 1 = rd.
illegal_op  out  1  one-cycle pulse on an unknown opcode.
halted  out  1  high while the FSM is in HALT.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Outputs are a pure function of the registered state (Moore). Exceptions: illegal_op is decoded in DECODE; the memory-done term feeds transitions only.
- Reset (rst=0), asynchronous: state=RESET, mem counter=0, retired=0. Every output is 0, including halted.
- States and transitions:
  - RESET -> FETCH on the first clock after rst deasserts.
  - FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1. Holds until memory is done. IRWrite and PCWrite are gated high only in the done cycle.
  - DECODE: ALUSrcB=11. Next state by opcode:
    - 000000 -> EXEC
    - 001000 -> ADDI_EX
    - 100011 and 101011 -> MEMADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 111111 -> HALT
    - any other -> FETCH, with illegal_op=1 this cycle and retired unchanged.
  - EXEC: ALUSrcA=1, ALUOp=10 -> RWB.
  - RWB: RegDst=1, RegWrite=1 -> FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10 -> ADDI_WB.
  - ADDI_WB: RegWrite=1 -> FETCH.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10 -> MEMRD for lw, MEMWR for sw. The opcode is re-read from the stable IR.
  - MEMRD: IorD=1, MemRead=1. Holds until done, then -> MEMWB.
  - MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR: IorD=1, MemWrite=1. Holds until done, then -> FETCH.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
  - HALT: halted=1, all other outputs 0. Terminal; only reset leaves HALT.
- Memory done:
  - MEM_MODE=0: a down-counter loads MEM_LAT-1 on entry to a memory state. Done when the counter is 0, so each access takes exactly MEM_LAT cycles.
  - MEM_MODE=1: done = mem_ready sampled in a memory state. mem_ready outside memory states is ignored. Strobes stay high for the whole wait, with no timeout.
- Latency with MEM_LAT=1: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each memory state adds MEM_LAT-1 cycles.
- retired increments by 1 on the exit from RWB, ADDI_WB, MEMWB, MEMWR, BRANCH and JUMP. It wraps modulo 2^CNT_W and does not increment on entry to HALT.
- Reset mid-operation aborts immediately, including mid-write: MemWrite drops asynchronously with rst.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum (4-bit encoding);
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT;
  - the ALUOp, ALUSrcB and PCSource encodings.
- Sub-module mem_wait_timer implements the MEM_MODE/MEM_LAT done logic (start, ready in; done out), keeping the FSM mode-agnostic.

Test Plan:
- Reset: rst low mid-MEMWR (MemWrite=1) -> every output 0 asynchronously. After release, FETCH on the next clock; retired=0.
- MEM_MODE=0, MEM_LAT=1, sequence addi, add, lw, sw, beq, j -> state traces of 4/4/5/4/3/3 cycles; retired=6 after j.
- MEM_MODE=0, MEM_LAT=3, lw -> MemRead high 3 cycles in FETCH and 3 in MEMRD; total 9 cycles.
- MEM_MODE=1, mem_ready held low 5 cycles in MEMWR -> MemWrite=1 and IorD=1 for those cycles; FETCH the cycle after mem_ready=1.
- Opcode 6'b110000 -> illegal_op=1 for exactly the DECODE cycle, then FETCH; retired unchanged.
- Opcode 6'b111111 -> halted=1 indefinitely, mem_ready toggling ignored, retired frozen. CNT_W=4 with 16 j instructions before the halt -> retired wraps to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
package multicycle_pkg;

  // FSM state encoding, 4 bits wide
  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_RWB     = 4'd4,
    S_ADDI_EX = 4'd5,
    S_ADDI_WB = 4'd6,
    S_MEMADDR = 4'd7,
    S_MEMRD   = 4'd8,
    S_MEMWB   = 4'd9,
    S_MEMWR   = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B         = 2'b00;
  localparam logic [1:0] SRCB_FOUR      = 2'b01;
  localparam logic [1:0] SRCB_IMM       = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore control word; 'fetch' marks FETCH so IRWrite/PCWrite can be gated by memory done
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       fetch;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
    logic       halted;
  } ctrl_t;

  // Control word produced while the FSM sits in a given state
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c          = '0;
    c.aluop    = ALUOP_ADD;
    c.alusrcb  = SRCB_B;
    c.pcsource = PCSRC_ALU;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.fetch   = 1'b1;
        c.alusrcb = SRCB_FOUR;
      end
      S_DECODE:  c.alusrcb = SRCB_IMM_SHIFT;
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_ADDI_EX, S_MEMADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_ADDI_WB: c.regwrite = 1'b1;
      S_MEMRD: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_JUMP;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // States that perform a memory access and wait for completion
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-access completion logic: fixed latency countdown or ready handshake.
module mem_wait_timer #(
  parameter int MEM_MODE = 0,
  parameter int MEM_LAT  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic ready,
  output logic done
);

  localparam logic [3:0] LOAD = 4'(MEM_LAT - 1);

  logic [3:0] count;

  // Load on entry to a memory state, then count down while the access is in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD;
    end else if (active && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = active && ((MEM_MODE == 0) ? (count == 4'd0) : ready);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore control FSM for the MIPS-subset shared-memory datapath.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int MEM_MODE = 0,
  parameter int MEM_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                illegal_op,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  state_t state_q;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   mem_done;
  logic   mem_start;
  logic   retire;
  logic   op_known;

  mem_wait_timer #(
    .MEM_MODE (MEM_MODE),
    .MEM_LAT  (MEM_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (mem_start),
    .active (is_mem_state(state_q)),
    .ready  (mem_ready),
    .done   (mem_done)
  );

  // Recognised opcodes; anything else is flagged in DECODE and dropped
  assign op_known = (opcode == OPCODE_W'(OP_RTYPE)) || (opcode == OPCODE_W'(OP_ADDI)) ||
                    (opcode == OPCODE_W'(OP_LW))    || (opcode == OPCODE_W'(OP_SW))   ||
                    (opcode == OPCODE_W'(OP_BEQ))   || (opcode == OPCODE_W'(OP_J))    ||
                    (opcode == OPCODE_W'(OP_HALT));

  // Next-state selection; memory states hold until the timer reports done
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_RESET:   state_next = S_FETCH;
      S_FETCH:   if (mem_done) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OPCODE_W'(OP_RTYPE))     state_next = S_EXEC;
        else if (opcode == OPCODE_W'(OP_ADDI)) state_next = S_ADDI_EX;
        else if ((opcode == OPCODE_W'(OP_LW)) || (opcode == OPCODE_W'(OP_SW)))
                                               state_next = S_MEMADDR;
        else if (opcode == OPCODE_W'(OP_BEQ))  state_next = S_BRANCH;
        else if (opcode == OPCODE_W'(OP_J))    state_next = S_JUMP;
        else if (opcode == OPCODE_W'(OP_HALT)) state_next = S_HALT;
        else                                   state_next = S_FETCH;
      end
      S_EXEC:    state_next = S_RWB;
      S_RWB:     state_next = S_FETCH;
      S_ADDI_EX: state_next = S_ADDI_WB;
      S_ADDI_WB: state_next = S_FETCH;
      S_MEMADDR: state_next = (opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_done) state_next = S_MEMWB;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   if (mem_done) state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_RESET;
    endcase
  end

  // Fresh memory access starts whenever the FSM moves into a memory state
  assign mem_start = is_mem_state(state_next) && (state_next != state_q);

  // Instruction completes on the last cycle of its final state
  assign retire = (state_q == S_RWB) || (state_q == S_ADDI_WB) || (state_q == S_MEMWB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                  ((state_q == S_MEMWR) && mem_done);

  // State, registered control word and retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
      retired <= '0;
    end else begin
      state_q <= state_next;
      ctrl_q  <= state_ctrl(state_next);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign PCWrite     = ctrl_q.pcwrite | (ctrl_q.fetch & mem_done);
  assign PCWriteCond = ctrl_q.pcwritecond;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.memread;
  assign MemWrite    = ctrl_q.memwrite;
  assign MemtoReg    = ctrl_q.memtoreg;
  assign IRWrite     = ctrl_q.fetch & mem_done;
  assign PCSource    = ctrl_q.pcsource;
  assign ALUOp       = ctrl_q.aluop;
  assign ALUSrcA     = ctrl_q.alusrca;
  assign ALUSrcB     = ctrl_q.alusrcb;
  assign RegWrite    = ctrl_q.regwrite;
  assign RegDst      = ctrl_q.regdst;
  assign halted      = ctrl_q.halted;
  assign illegal_op  = (state_q == S_DECODE) && !op_known;

endmodule
